d_latch: RTL and testbench

// - Level-sensitive D latch with complementary outputs, emulated synchronously for FPGA/ASIC flows

---
 rtl/d_latch.sv | 52 +++++
 tb/tb_d_latch.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/d_latch.sv
// Purpose: level-sensitive D latch with complementary outputs, built from a flop plus output mux.
// Latency: 0 cycles d->q while transparent with COMB_BYPASS=1, otherwise 1 cycle.
// Backpressure: none; en gates capture, no handshake.
module d_latch #(
    parameter int               WIDTH       = 1,
    parameter int               COMB_BYPASS = 1,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] q_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= RESET_VAL;
        end else if (en) begin
            h <= d;
        end
    end

    // Reset overrides the bypass path so q never leaks d while rst_n is low.
    generate
        if (COMB_BYPASS != 0) begin : g_bypass
            always_comb begin
                q_int = h;
                if (!rst_n) begin
                    q_int = RESET_VAL;
                end else if (en) begin
                    q_int = d;
                end
            end
        end else begin : g_registered
            always_comb begin
                q_int = h;
                if (!rst_n) begin
                    q_int = RESET_VAL;
                end
            end
        end
    endgenerate

    assign q   = q_int;
    assign q_n = ~q_int;

endmodule

// File: tb/tb_d_latch.sv
// Purpose: directed self-checking bench for d_latch in bypass/registered modes, 1- and 8-bit.
// Latency: inputs driven 1 time unit after rising clk, outputs sampled before the next edge.
// Backpressure: not applicable.
module tb_d_latch;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       d1;
    logic [7:0] d8;

    logic       q_byp,  qn_byp;
    logic       q_reg,  qn_reg;
    logic [7:0] q_byp8, qn_byp8;
    logic [7:0] q_reg8, qn_reg8;
    logic [7:0] q_rv,   qn_rv;

    int n_checks;
    int n_fail;

    d_latch #(.WIDTH(1), .COMB_BYPASS(1), .RESET_VAL(1'b0)) u_byp (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d1), .q(q_byp), .q_n(qn_byp)
    );
    d_latch #(.WIDTH(1), .COMB_BYPASS(0), .RESET_VAL(1'b0)) u_reg (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d1), .q(q_reg), .q_n(qn_reg)
    );
    d_latch #(.WIDTH(8), .COMB_BYPASS(1), .RESET_VAL(8'h00)) u_byp8 (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d8), .q(q_byp8), .q_n(qn_byp8)
    );
    d_latch #(.WIDTH(8), .COMB_BYPASS(0), .RESET_VAL(8'h00)) u_reg8 (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d8), .q(q_reg8), .q_n(qn_reg8)
    );
    d_latch #(.WIDTH(8), .COMB_BYPASS(0), .RESET_VAL(8'h3C)) u_rv (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d8), .q(q_rv), .q_n(qn_rv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        d1    = 1'b1;
        d8    = 8'hFF;

        // Reset asserted before any clock edge
        #3;
        check_val("rst_byp_q",  {7'b0, q_byp},  8'h00);
        check_val("rst_byp_qn", {7'b0, qn_byp}, 8'h01);
        check_val("rst_reg_q",  {7'b0, q_reg},  8'h00);
        check_val("rst_reg_qn", {7'b0, qn_reg}, 8'h01);
        check_val("rst_rv_q",   q_rv,  8'h3C);
        check_val("rst_rv_qn",  qn_rv, 8'hC3);

        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("post_rst_byp_q", {7'b0, q_byp}, 8'h00);
            check_val("post_rst_reg_q", {7'b0, q_reg}, 8'h00);
            check_val("post_rst_rv_q",  q_rv, 8'h3C);
        end

        // Transparent
        en = 1'b1; d1 = 1'b0;
        #2;
        check_val("tr0_byp_q",  {7'b0, q_byp},  8'h00);
        check_val("tr0_byp_qn", {7'b0, qn_byp}, 8'h01);
        tick();
        check_val("tr0_reg_q",  {7'b0, q_reg},  8'h00);
        d1 = 1'b1;
        #2;
        check_val("tr1_byp_q",      {7'b0, q_byp},  8'h01);
        check_val("tr1_byp_qn",     {7'b0, qn_byp}, 8'h00);
        check_val("tr1_reg_latency", {7'b0, q_reg}, 8'h00);
        tick();
        check_val("tr1_reg_q",  {7'b0, q_reg},  8'h01);
        check_val("tr1_reg_qn", {7'b0, qn_reg}, 8'h00);
        d1 = 1'b0;
        #2;
        check_val("tr2_byp_q", {7'b0, q_byp}, 8'h00);
        tick();
        check_val("tr2_reg_q", {7'b0, q_reg}, 8'h00);

        // Hold 0: en falls with d rising; the rise is not captured
        en = 1'b0; d1 = 1'b1;
        #2;
        check_val("hold0_byp_q",  {7'b0, q_byp},  8'h00);
        check_val("hold0_byp_qn", {7'b0, qn_byp}, 8'h01);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("hold0_byp_cyc", {7'b0, q_byp}, 8'h00);
            check_val("hold0_reg_cyc", {7'b0, q_reg}, 8'h00);
        end

        // Hold 1 with d toggling underneath
        en = 1'b1; d1 = 1'b1;
        tick();
        en = 1'b0;
        #2;
        check_val("hold1_byp_q", {7'b0, q_byp}, 8'h01);
        for (int i = 0; i < 6; i++) begin
            d1 = ~d1;
            tick();
            check_val("hold1_byp_q",  {7'b0, q_byp},  8'h01);
            check_val("hold1_byp_qn", {7'b0, qn_byp}, 8'h00);
            check_val("hold1_reg_q",  {7'b0, q_reg},  8'h01);
        end

        // Async reset pulse between edges
        en = 1'b1; d1 = 1'b1;
        tick();
        check_val("pre_ar_byp_q", {7'b0, q_byp}, 8'h01);
        check_val("pre_ar_reg_q", {7'b0, q_reg}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_byp_q",  {7'b0, q_byp},  8'h00);
        check_val("ar_byp_qn", {7'b0, qn_byp}, 8'h01);
        check_val("ar_reg_q",  {7'b0, q_reg},  8'h00);
        check_val("ar_reg_qn", {7'b0, qn_reg}, 8'h01);
        check_val("ar_rv_q",   q_rv, 8'h3C);
        rst_n = 1'b1;
        #1;
        check_val("ar_rel_byp_q", {7'b0, q_byp}, 8'h01);
        check_val("ar_rel_reg_q", {7'b0, q_reg}, 8'h00);
        tick();
        check_val("ar_edge_reg_q", {7'b0, q_reg}, 8'h01);
        check_val("ar_edge_rv_q",  q_rv, 8'hFF);

        // 8-bit: d8 was FF through the last enabled edge
        d8 = 8'hA5;
        #2;
        check_val("w8_byp_q",       q_byp8,  8'hA5);
        check_val("w8_byp_qn",      qn_byp8, 8'h5A);
        check_val("w8_reg_latency", q_reg8,  8'hFF);
        tick();
        check_val("w8_reg_q",  q_reg8,  8'hA5);
        check_val("w8_reg_qn", qn_reg8, 8'h5A);
        en = 1'b0; d8 = 8'hFF;
        #2;
        check_val("w8_hold_byp_q", q_byp8, 8'hA5);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("w8_hold_byp_q", q_byp8,  8'hA5);
            check_val("w8_hold_reg_q", q_reg8,  8'hA5);
            check_val("w8_hold_reg_qn", qn_reg8, 8'h5A);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
